// File: rtl/mult_if_bit_packer_if.sv
// Bus bundle for mult_if_bit_packer: serial bit input handshake and packed word output handshake.
// The slave modport is the packer; the master modport is the surrounding producer/consumer.
// Optional: MULT_IF_PACK_PARITY_EN adds the out_parity signal.
interface mult_if_bit_packer_if #(
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             z_in;
  logic             z_valid;
  logic             z_last;
  logic             z_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
`ifdef MULT_IF_PACK_PARITY_EN
  logic             out_parity;
`endif

  modport slave (
    input  z_in,
    input  z_valid,
    input  z_last,
    output z_ready,
    output out_data,
    output out_count,
    output out_last,
    output out_valid,
`ifdef MULT_IF_PACK_PARITY_EN
    output out_parity,
`endif
    input  out_ready
  );

  modport master (
    output z_in,
    output z_valid,
    output z_last,
    input  z_ready,
    input  out_data,
    input  out_count,
    input  out_last,
    input  out_valid,
`ifdef MULT_IF_PACK_PARITY_EN
    input  out_parity,
`endif
    output out_ready
  );
endinterface

// File: rtl/mult_if_bit_packer.sv
// Serial-to-parallel bit packer: collects LSB-first bits into WIDTH-bit words, closing early
// on z_last with an explicit bit count. One pending word is kept in the shift register when
// the output register is busy; input is stalled only while that pending word waits.
// Optional: define MULT_IF_PACK_PARITY_EN to add out_parity (even parity of the valid bits).
module mult_if_bit_packer #(
  parameter int unsigned WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  mult_if_bit_packer_if.slave bus
);
  localparam int unsigned     CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH - 1);

  // Input assembly state
  logic [WIDTH-1:0] sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pending_q;
  logic [CNT_W-1:0] pend_count_q;
  logic             pend_last_q;

  // Output register
  logic [WIDTH-1:0] out_data_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_last_q;
  logic             out_valid_q;
`ifdef MULT_IF_PACK_PARITY_EN
  logic             out_parity_q;
`endif

  // Combinational helpers
  logic [WIDTH-1:0] sr_merged;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] word_count;
  logic             accept;
  logic             complete;
  logic             out_free;
  logic             retire;
  logic             drain;
  logic             direct_load;

  // Merge the incoming bit into the shift register and mask stale bits above the new count.
  always_comb begin
    sr_merged = sr_q;
    word      = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i == int'(cnt_q)) begin
        sr_merged[i] = bus.z_in;
      end
      if (i <= int'(cnt_q)) begin
        word[i] = sr_merged[i];
      end
    end
  end

  // Handshake and event decode
  always_comb begin
    word_count  = cnt_q + CNT_W'(1);
    accept      = bus.z_valid && !pending_q;
    complete    = accept && (bus.z_last || (cnt_q == CntMax));
    out_free    = !out_valid_q || bus.out_ready;
    retire      = out_valid_q && bus.out_ready;
    // pending blocks accept, so drain and direct_load are mutually exclusive
    drain       = pending_q && out_free;
    direct_load = complete && out_free;
  end

  // Bit accumulation and pending-word bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      pend_count_q <= '0;
      pend_last_q  <= 1'b0;
    end else begin
      if (accept) begin
        if (complete) begin
          cnt_q <= '0;
          if (!out_free) begin
            // Park the masked word in sr until the output register frees up
            sr_q         <= word;
            pending_q    <= 1'b1;
            pend_count_q <= word_count;
            pend_last_q  <= bus.z_last;
          end
        end else begin
          sr_q  <= sr_merged;
          cnt_q <= word_count;
        end
      end
      if (drain) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Output register: load from pending word or freshly completed word, else retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
`ifdef MULT_IF_PACK_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else if (drain) begin
      out_data_q   <= sr_q;
      out_count_q  <= pend_count_q;
      out_last_q   <= pend_last_q;
      out_valid_q  <= 1'b1;
`ifdef MULT_IF_PACK_PARITY_EN
      out_parity_q <= ^sr_q;
`endif
    end else if (direct_load) begin
      out_data_q   <= word;
      out_count_q  <= word_count;
      out_last_q   <= bus.z_last;
      out_valid_q  <= 1'b1;
`ifdef MULT_IF_PACK_PARITY_EN
      out_parity_q <= ^word;
`endif
    end else if (retire) begin
      // Data/count/last hold their stale values once retired
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.z_ready    = !pending_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_count  = out_count_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = out_valid_q;
`ifdef MULT_IF_PACK_PARITY_EN
  assign bus.out_parity = out_parity_q;
`endif

  // A stalled word must not change under the consumer
  a_out_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q)
                                           && $stable(out_count_q) && $stable(out_last_q)));

  // A pending word implies the output register is occupied
  a_pending_busy : assert property (@(posedge clk) disable iff (!rst_n)
      pending_q |-> out_valid_q);

endmodule

// File: tb/tb_mult_if_bit_packer.sv
// Bench for mult_if_bit_packer: directed scenarios with literal expectations, then random
// traffic checked every cycle against a word-queue model of the packer.
module tb_mult_if_bit_packer;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  mult_if_bit_packer_if #(.WIDTH(WIDTH)) bus ();

  mult_if_bit_packer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ordered list of words the packer owes the consumer, plus the frame being built.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               count;
    bit               last;
  } word_t;

  word_t            exp_q[$];
  logic [WIDTH-1:0] cur_bits = '0;
  int               cur_n = 0;

  // Compare DUT against model each cycle, then advance model across the coming rising edge
  always @(negedge clk) begin
    bit    can_take;
    word_t w;
    if (!rst_n) begin
      exp_q.delete();
      cur_bits = '0;
      cur_n    = 0;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data",  bus.out_data,  0);
      check("rst_out_count", bus.out_count, 0);
      check("rst_out_last",  bus.out_last,  0);
      check("rst_z_ready",   bus.z_ready,   1);
`ifdef MULT_IF_PACK_PARITY_EN
      check("rst_out_parity", bus.out_parity, 0);
`endif
    end else begin
      // Packer holds at most an output word plus one pending word
      can_take = exp_q.size() < 2;
      check("z_ready",   bus.z_ready,   can_take);
      check("out_valid", bus.out_valid, exp_q.size() > 0);
      if (bus.out_valid && exp_q.size() > 0) begin
        check("out_data",  bus.out_data,  exp_q[0].data);
        check("out_count", bus.out_count, exp_q[0].count);
        check("out_last",  bus.out_last,  exp_q[0].last);
`ifdef MULT_IF_PACK_PARITY_EN
        check("out_parity", bus.out_parity, ^exp_q[0].data);
`endif
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (bus.z_valid && can_take) begin
        cur_bits[cur_n] = bus.z_in;
        cur_n++;
        if (cur_n == int'(WIDTH) || bus.z_last) begin
          w.data  = cur_bits;
          w.count = cur_n;
          w.last  = bus.z_last;
          exp_q.push_back(w);
          cur_bits = '0;
          cur_n    = 0;
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic last);
    bit r;
    int n;
    r = 1'b0;
    n = 0;
    bus.z_in    = b;
    bus.z_valid = 1'b1;
    bus.z_last  = last;
    do begin
      @(negedge clk);
      r = bus.z_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    check("bit_accepted", r, 1);
    bus.z_valid = 1'b0;
    bus.z_last  = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int n, input bit last);
    for (int i = 0; i < n; i++) send_bit(w[i], last && (i == n - 1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.z_in      = 1'b0;
    bus.z_valid   = 1'b0;
    bus.z_last    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Full word 0x4D
    bus.out_ready = 1'b1;
    send_word(8'h4D, 8, 1'b0);
    check("full_valid", bus.out_valid, 1);
    check("full_data",  bus.out_data,  8'h4D);
    check("full_count", bus.out_count, 8);
    check("full_last",  bus.out_last,  0);
`ifdef MULT_IF_PACK_PARITY_EN
    check("full_parity", bus.out_parity, 0);
`endif
    idle(2);

    // Partial frame 1,1,0 with z_last
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check("part_data",  bus.out_data,  8'h03);
    check("part_count", bus.out_count, 3);
    check("part_last",  bus.out_last,  1);
`ifdef MULT_IF_PACK_PARITY_EN
    check("part_parity", bus.out_parity, 0);
`endif
    idle(1);

    // Next frame starts from bit 0
    send_word(8'h07, 8, 1'b0);
    check("w07_data", bus.out_data, 8'h07);
`ifdef MULT_IF_PACK_PARITY_EN
    check("w07_parity", bus.out_parity, 1);
`endif
    idle(2);

    // Backpressure: 0xA5 held, 0x3C pends, input stalls
    bus.out_ready = 1'b0;
    send_word(8'hA5, 8, 1'b0);
    send_word(8'h3C, 8, 1'b0);
    check("bp_hold_data", bus.out_data, 8'hA5);
    check("bp_z_ready",   bus.z_ready,  0);
    idle(3);
    check("bp_still_data", bus.out_data, 8'hA5);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_next_valid", bus.out_valid, 1);
    check("bp_next_data",  bus.out_data,  8'h3C);
    check("bp_z_ready_back", bus.z_ready, 1);
    idle(2);
    bus.out_ready = 1'b1;
    idle(2);

    // Back-to-back words with retire on the completion edge
    send_word(8'hFF, 8, 1'b0);
    check("b2b_first", bus.out_data, 8'hFF);
    send_word(8'h00, 8, 1'b0);
    check("b2b_second", bus.out_data, 8'h00);
    check("b2b_count",  bus.out_count, 8);
    idle(2);

    // Reset mid-word discards the partial frame
    send_word(8'h1F, 5, 1'b0);
    rst_n = 1'b0;
    idle(2);
    check("mid_rst_valid",   bus.out_valid, 0);
    check("mid_rst_data",    bus.out_data,  0);
    check("mid_rst_z_ready", bus.z_ready,   1);
    rst_n = 1'b1;
    idle(1);
    send_word(8'h81, 8, 1'b0);
    check("post_rst_data",  bus.out_data,  8'h81);
    check("post_rst_count", bus.out_count, 8);
    idle(2);

    // Random traffic; bits offered while stalled must be ignored
    for (int c = 0; c < 4000; c++) begin
      bus.z_valid   = $urandom_range(0, 3) != 0;
      bus.z_in      = 1'($urandom);
      bus.z_last    = $urandom_range(0, 9) == 0;
      bus.out_ready = $urandom_range(0, 2) != 0;
      if (c == 2000) rst_n = 1'b0;
      if (c == 2002) rst_n = 1'b1;
      @(posedge clk);
      #1;
    end

    // Drain everything owed
    bus.z_valid   = 1'b0;
    bus.z_last    = 1'b0;
    bus.out_ready = 1'b1;
    idle(6);
    check("drain_empty", exp_q.size(), 0);
    check("drain_valid", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
